// File: rtl/timer_counter.sv
// Counting engine of the 8-bit APB timer: prescaled up/down counter with load.
// Optional one-shot halt on wrap is enabled by defining TIMER_COUNTER_ONESHOT_EN.
module timer_counter #(
    parameter int WIDTH = 8,
    parameter int PSC_W = 4
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             TCR_EN,
    input  logic             TCR_UPDN,
    input  logic             TCR_LOAD,
    input  logic [1:0]       TCR_CKS,
    input  logic [WIDTH-1:0] TDR,
`ifdef TIMER_COUNTER_ONESHOT_EN
    input  logic             TCR_ONESHOT,
`endif
    output logic [WIDTH-1:0] COUNT_OUT,
    output logic             TICK,
    output logic             RUNNING
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [PSC_W-1:0] psc, psc_next, psc_mask;
    logic [WIDTH-1:0] count_next;
    logic             oneshot_wrap;

    // Low CKS+1 prescaler bits all ones gives a tick every 2^(CKS+1) cycles.
    always_comb begin
        psc_mask = '0;
        for (int unsigned i = 0; i < PSC_W; i++) begin
            psc_mask[i] = (i <= {30'b0, TCR_CKS});
        end
    end

    assign TICK    = (state == RUN) && ((psc & psc_mask) == psc_mask);
    assign RUNNING = (state == RUN);

`ifdef TIMER_COUNTER_ONESHOT_EN
    logic wrap;
    assign wrap         = TCR_UPDN ? (COUNT_OUT == '0) : (COUNT_OUT == '1);
    assign oneshot_wrap = TCR_ONESHOT && TICK && wrap && !TCR_LOAD;
`else
    assign oneshot_wrap = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (TCR_EN) state_next = RUN;
            RUN: begin
                if (!TCR_EN)          state_next = IDLE;
                else if (oneshot_wrap) state_next = HALT;
            end
            HALT: begin
                if (!TCR_EN)       state_next = IDLE;
                else if (TCR_LOAD) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        psc_next   = '0;
        count_next = COUNT_OUT;
        if (!TCR_LOAD && state == RUN && TCR_EN) psc_next = psc + 1'b1;
        // Load wins over a coincident tick: no count step on that edge.
        if (TCR_LOAD)  count_next = TDR;
        else if (TICK) count_next = TCR_UPDN ? COUNT_OUT - 1'b1 : COUNT_OUT + 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            psc       <= '0;
            COUNT_OUT <= '0;
        end else begin
            state     <= state_next;
            psc       <= psc_next;
            COUNT_OUT <= count_next;
        end
    end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Counting engine of the 8-bit APB timer. Produces COUNT_OUT, which feeds the overflow/underflow comparator's COUNT_IN.
- Takes control bits and the reload value from the APB register block.
- A programmable prescaler divides PCLK. On each prescaler tick the counter counts up or down, with natural wrap-around. The comparator detects the wrap.

Parameters:
- WIDTH, 8, counter and reload data width.
- PSC_W, 4, prescaler width; supports divide-by 2/4/8/16.

Ports:
- PCLK  input  1  system clock, rising edge
- PRESETn  input  1  asynchronous active-low reset
- TCR_EN  input  1  count enable (level)
- TCR_UPDN  input  1  0 = count up, 1 = count down
- TCR_LOAD  input  1  synchronous load request (one-PCLK pulse)
- TCR_CKS  input  2  prescaler select: 00 = /2, 01 = /4, 10 = /8, 11 = /16
- TDR  input  WIDTH  reload value
- COUNT_OUT  output  WIDTH  current count, to comparator COUNT_IN
- TICK  output  1  prescaler tick (combinational), high for one PCLK per count step
- RUNNING  output  1  high while FSM is in RUN

Behaviour:
- Clocking and reset:
  - One clock: PCLK, rising edge.
  - Reset is asynchronous and active-low on PRESETn.
  - While PRESETn=0: COUNT_OUT=0, prescaler=0, FSM=IDLE, RUNNING=0, TICK=0. Effect is immediate, independent of PCLK.
  - Mid-operation reset discards the count and prescaler state.
- FSM states:
  - IDLE: TCR_EN=0. Prescaler held at 0; COUNT_OUT held.
  - RUN: TCR_EN=1. Prescaler increments every PCLK and wraps naturally.
  - HALT: one-shot only, see Optional Feature.
- FSM transitions:
  - IDLE -> RUN when TCR_EN=1.
  - RUN -> IDLE when TCR_EN=0; prescaler cleared on that edge.
  - HALT -> IDLE on TCR_EN=0.
  - HALT -> RUN on TCR_LOAD.
- Tick generation:
  - TICK = (state==RUN) & (prescaler[TCR_CKS:0] all ones).
  - Period is 2^(TCR_CKS+1) PCLKs.
  - First tick occurs on the 2^(TCR_CKS+1)-th PCLK edge after entering RUN.
  - TCR_CKS change mid-run takes effect on the next cycle; prescaler is not cleared.
- Count update, registered on the same rising edge where TICK=1:
  - Up: COUNT_OUT+1 modulo 2^WIDTH, so FF -> 00.
  - Down: COUNT_OUT-1 modulo 2^WIDTH, so 00 -> FF.
  - TCR_UPDN is sampled at the tick edge.
- Load:
  - TCR_LOAD=1 at an edge: COUNT_OUT <= TDR and prescaler <= 0, in any state.
  - Load has priority over a coincident tick; no count step occurs that cycle.
  - Load while IDLE updates COUNT_OUT without starting the count.
  - Latency: COUNT_OUT shows TDR one edge after TCR_LOAD is sampled.
- Every wrap appears on COUNT_OUT as exactly one FF->00 or 00->FF step, so the comparator flags it once.

Optional Feature:
- Macro: TIMER_COUNTER_ONESHOT_EN.
- Defined:
  - Adds input TCR_ONESHOT (1 bit).
  - In RUN with TCR_ONESHOT=1, the tick edge that wraps the counter moves the FSM to HALT.
  - COUNT_OUT shows the wrapped value (00 up, FF down) and holds; TICK=0; RUNNING=0.
  - The comparator still sees that one wrap.
  - HALT exits on TCR_LOAD (-> RUN if TCR_EN=1, else IDLE) or on TCR_EN=0 (-> IDLE).
- Not defined:
  - Port absent; HALT unreachable; the counter free-runs and wraps indefinitely.

Test Plan:
- Reset: PRESETn=0 asserted between PCLK edges with COUNT_OUT=5A -> COUNT_OUT=00 and RUNNING=0 immediately, before the next PCLK edge.
- Up/divide: TCR_EN=1, TCR_UPDN=0, TCR_CKS=00, from 00 -> COUNT_OUT = 01, 02, 03 on PCLK edges 2, 4, 6; TICK high on exactly those cycles.
- Up wrap: load TDR=FE, then run up with TCR_CKS=01 -> sequence FE, FF, 00, 01, one step per 4 PCLKs; single FF->00 step.
- Down wrap: load TDR=01, TCR_UPDN=1, TCR_CKS=00 -> sequence 01, 00, FF, FE, one step per 2 PCLKs.
- Load on a tick edge: TCR_LOAD with TDR=80 on a cycle where TICK=1 -> COUNT_OUT=80 (not 81). Next step occurs 2^(CKS+1) PCLKs later. Also: TCR_EN=0 mid-count -> COUNT_OUT holds, TICK stays 0.
- One-shot (macro defined): TCR_ONESHOT=1, load FF, count up -> COUNT_OUT=00 and holds for 50 cycles; RUNNING=0. TCR_LOAD with TDR=10 -> counting resumes from 10.
